// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: operand forwarding, load-use/branch stall-flush and the mul/div hold FSM.
// Define HAZARD_PERF_CNT_EN to add saturating StallCnt/FlushCnt performance counters.
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MulDivE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        MdBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [7:0] cnt;
  logic lwStall, mdStall, fwdM1, fwdM2, fwdW1, fwdW2;
  assign fwdM1 = RegWriteM && RdM != '0 && RdM == Rs1E;
  assign fwdM2 = RegWriteM && RdM != '0 && RdM == Rs2E;
  assign fwdW1 = RegWriteW && RdW != '0 && RdW == Rs1E;
  assign fwdW2 = RegWriteW && RdW != '0 && RdW == Rs2E;
  assign ForwardAE = fwdM1 ? 2'b10 : fwdW1 ? 2'b01 : 2'b00;
  assign ForwardBE = fwdM2 ? 2'b10 : fwdW2 ? 2'b01 : 2'b00;
  assign lwStall = ResultSrcE == 2'b01 && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  // Gated by rst_n so an op sitting in E during reset cannot raise a stall.
  assign mdStall = rst_n && (state == BUSY || (state == IDLE && MulDivE));
  assign MdBusy = state == BUSY;
  assign StallF = lwStall || mdStall;
  assign StallD = StallF;
  assign StallE = mdStall;
  assign FlushD = PCSrcE;
  assign FlushE = (lwStall || PCSrcE) && !mdStall;
  // BUSY lasts MD_CYCLES-2 cycles: leave when the decrement reaches zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state == IDLE ? (MulDivE ? BUSY : IDLE) :
               state == BUSY ? (cnt == 8'd1 ? DONE : BUSY) : IDLE;
      cnt   <= state == IDLE && MulDivE ? 8'(MD_CYCLES - 2) :
               state == BUSY ? cnt - 8'd1 : cnt;
    end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && !(&StallCnt)) StallCnt <= StallCnt + 32'd1;
      if ((FlushD || FlushE) && !(&FlushCnt)) FlushCnt <= FlushCnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl (MD_CYCLES=8).
module tb_pipeline_hazard_ctrl;
  localparam int MD = 8;
  logic clk = 0, rst_n = 0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic RegWriteM, RegWriteW, PCSrcE, MulDivE;
  logic StallF, StallD, StallE, FlushD, FlushE, MdBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif
  logic [9:0] obs;
  typedef struct {string tag; logic [9:0] exp;} item_t;
  item_t q[$];
  int checks = 0, errors = 0;
  pipeline_hazard_ctrl #(.MD_CYCLES(MD)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MulDivE(MulDivE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .MdBusy(MdBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, MdBusy};
  function automatic logic [9:0] o(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd,
                                   logic se, logic fd, logic fe, logic mb);
    return {fa, fb, sf, sd, se, fd, fe, mb};
  endfunction
  task automatic expect_out(string tag, logic [9:0] e);
    q.push_back('{tag, e});
  endtask
  task automatic check_out();
    item_t it;
    it = q.pop_front();
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
    end
  endtask
  task automatic step(string tag, logic [9:0] e);
    expect_out(tag, e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {RegWriteM, RegWriteW, PCSrcE, MulDivE} = '0;
  endtask
  task automatic check_cnt(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask
  initial begin
    logic s, b;
    clr();
    #3;
    expect_out("reset_zero", o(0, 0, 0, 0, 0, 0, 0, 0));
    check_out();
    MulDivE = 1;
    #1;
    expect_out("reset_md_gated", o(0, 0, 0, 0, 0, 0, 0, 0));
    check_out();
    MulDivE = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5;
    step("fwd_m", o(2'b10, 0, 0, 0, 0, 0, 0, 0));
    RegWriteM = 0;
    step("fwd_w", o(2'b01, 0, 0, 0, 0, 0, 0, 0));
    RegWriteM = 1; RdM = 6; Rs1E = 6; Rs2E = 5;
    step("fwd_mix", o(2'b10, 2'b01, 0, 0, 0, 0, 0, 0));
    RdM = 5; Rs1E = 5;
    step("fwd_prio", o(2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
    RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    step("fwd_x0", o(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    step("lw_rs2", o(0, 0, 1, 1, 0, 0, 1, 0));
    clr();
    step("lw_release", o(0, 0, 0, 0, 0, 0, 0, 0));
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    step("lw_rs1", o(0, 0, 1, 1, 0, 0, 1, 0));
    RdE = 0; Rs1D = 0;
    step("lw_x0", o(0, 0, 0, 0, 0, 0, 0, 0));
    ResultSrcE = 2'b00; RdE = 7; Rs1D = 7;
    step("lw_notload", o(0, 0, 0, 0, 0, 0, 0, 0));
    clr(); PCSrcE = 1;
    step("branch", o(0, 0, 0, 0, 0, 1, 1, 0));
    PCSrcE = 0;
    step("branch_off", o(0, 0, 0, 0, 0, 0, 0, 0));
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    step("branch_lw", o(0, 0, 1, 1, 0, 1, 1, 0));
    clr();
    for (int i = 0; i < MD; i++) begin
      MulDivE = 1;
      ResultSrcE = (i == 2 || i == 3) ? 2'b01 : 2'b00;
      RdE = (i == 2 || i == 3) ? 5'd9 : 5'd0;
      Rs1D = RdE;
      s = i <= MD - 2;
      b = i >= 1 && i <= MD - 2;
      step($sformatf("md_%0d", i), o(0, 0, s, s, s, 0, 0, b));
    end
    clr();
    step("md_idle", o(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2 * MD; i++) begin
      MulDivE = 1;
      s = (i % MD) <= MD - 2;
      b = (i % MD) >= 1 && (i % MD) <= MD - 2;
      step($sformatf("b2b_%0d", i), o(0, 0, s, s, s, 0, 0, b));
    end
    MulDivE = 0;
    step("b2b_idle", o(0, 0, 0, 0, 0, 0, 0, 0));
    MulDivE = 1;
    for (int i = 0; i < 4; i++)
      step($sformatf("pre_rst_%0d", i), o(0, 0, 1, 1, 1, 0, 0, i >= 1));
    rst_n = 0;
    #1;
    expect_out("rst_async", o(0, 0, 0, 0, 0, 0, 0, 0));
    check_out();
    @(posedge clk);
    MulDivE = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < MD; i++) begin
      MulDivE = 1;
      s = i <= MD - 2;
      b = i >= 1 && i <= MD - 2;
      step($sformatf("restart_%0d", i), o(0, 0, s, s, s, 0, 0, b));
    end
    MulDivE = 0;
    step("restart_idle", o(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("stall_cnt", StallCnt, 32'(MD - 1));
    check_cnt("flush_cnt", FlushCnt, 32'd0);
    PCSrcE = 1;
    step("perf_branch", o(0, 0, 0, 0, 0, 1, 1, 0));
    PCSrcE = 0;
    check_cnt("flush_cnt_1", FlushCnt, 32'd1);
    rst_n = 0;
    #1;
    check_cnt("stall_cnt_rst", StallCnt, 32'd0);
    check_cnt("flush_cnt_rst", FlushCnt, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline core. Generates forwarding selects for the execute-stage operand muxes, stall/flush controls for fetch, decode and execute, and sequences multi-cycle execute operations (iterative mul/div) with a hold FSM. Sits beside the stage modules and drives their enable and flush inputs; it holds no datapath state.

## Interface
Parameters:
- MD_CYCLES, 8: total cycles a multi-cycle op occupies E, including its release cycle; legal range 3..255.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers of the D-stage instruction
- Rs1E, Rs2E, RdE  in  5  sources and destination of the E-stage instruction
- ResultSrcE  in  2  E-stage result select; 2'b01 = load
- RdM, RdW  in  5  destinations in M and W
- RegWriteM, RegWriteW  in  1  register-write enables in M and W
- PCSrcE  in  1  branch taken or jump resolved in E
- MulDivE  in  1  E-stage instruction is a multi-cycle op
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  out  1  hold the PC, the D register and the E register
- FlushD, FlushE  out  1  bubble the D register and the E register
- MdBusy  out  1  high while the FSM is in BUSY
- StallCnt, FlushCnt  out  32  performance counters; present only with HAZARD_PERF_CNT_EN

## Operation
- Forwarding (combinational, per operand X ∈ {1,2}): 10 if RegWriteM and RdM≠0 and RdM==RsXE; else 01 if RegWriteW and RdW≠0 and RdW==RsXE; else 00. M has priority over W. x0 is never forwarded.
- Load-use: lwStall = (ResultSrcE==2'b01) and RdE≠0 and (RdE==Rs1D or RdE==Rs2D). Produces StallF=StallD=1 and FlushE=1.
- Control hazard: PCSrcE=1 produces FlushD=1 and FlushE=1. FlushE from PCSrcE coincides with the lwStall FlushE; StallF/StallD from lwStall still apply in that cycle.
- Multi-cycle FSM states:
  - IDLE: on MulDivE=1, assert mdStall combinationally in the same cycle, load the counter with MD_CYCLES-2 and go to BUSY.
  - BUSY: mdStall=1 and MdBusy=1. The counter decrements each cycle. When the counter is 0, go to DONE.
  - DONE: mdStall=0 for one cycle and the E instruction advances. MulDivE is ignored in DONE. Next state is IDLE.
- mdStall drives StallF=StallD=StallE=1.
- Priority: while StallE=1, FlushE is forced to 0 so the held op is not killed. FlushD still follows PCSrcE, but PCSrcE cannot legally be 1 while a mul/div holds E.
- Reset at any point, including mid-BUSY: FSM goes to IDLE, the counter goes to 0, and the perf counters go to 0. The FSM-derived stall terms are 0 immediately (asynchronously). The held op is discarded by the pipeline reset.

## Timing
- Forward*, lwStall and PCSrcE terms: zero latency, purely combinational from the inputs.
- Multi-cycle op entering E at cycle t:
  - StallF/D/E are high for cycles t .. t+MD_CYCLES-2.
  - Low at t+MD_CYCLES-1, the DONE cycle.
  - The op leaves E at the clock edge ending that cycle.
  - MdBusy is high for t+1 .. t+MD_CYCLES-2.
- Back-to-back multi-cycle ops: the second reaches E in the cycle after DONE. It is seen from IDLE with no gap cycle.
- Output values while rst_n=0: MdBusy=0 and all FSM stall terms 0. The remaining outputs follow the combinational equations with the FSM at IDLE; with all-zero inputs every output is 0.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments every cycle StallF=1.
  - FlushCnt increments every cycle FlushD=1 or FlushE=1.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF and reset to 0.
- HAZARD_PERF_CNT_EN undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Forward select: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0 with Rs1E=0 -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. With RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1 in that cycle only; no stall.
- Mul/div, MD_CYCLES=8: MulDivE rises at cycle 10 -> StallE high in cycles 10..16, MdBusy high in 11..16, stalls low at 17, FSM in IDLE at 18.
- Mul/div with a coincident load-use: during BUSY, lwStall conditions are present -> FlushE stays 0 and StallE stays 1.
- Reset: drop rst_n at cycle 13 of the mul/div case -> MdBusy and stalls 0 asynchronously. After release, MulDivE=1 restarts a full MD_CYCLES sequence. With HAZARD_PERF_CNT_EN: StallCnt=7 after one uninterrupted MD_CYCLES=8 op, and 0 after reset.
